ex_muldiv_stage: RTL and testbench

Parametrised execute stage for the in-order integer pipeline, placed between the ID/EX register and the MEM stage. It performs single-cycle logic, shift, add/subtract and compare operations, and iterative signed/unsigned multiply and divide that write HI/LO. All results leave through a registered EX/MEM-side output. Multi-cycle operations hold the upstream pipeline through `stall_req_o` until the result is ready.

---
 rtl/ex_muldiv_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle logic/shift/arith/compare ops plus an iterative
// radix-2 multiply/divide unit that writes HI/LO and stalls upstream while busy.
module ex_muldiv_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [4:0]        op_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              reg_write_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              write_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              hilo_we_o,
    output logic              stall_req_o
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

    localparam logic [4:0] OP_OR    = 5'd0;
    localparam logic [4:0] OP_AND   = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_NOR   = 5'd3;
    localparam logic [4:0] OP_SLL   = 5'd4;
    localparam logic [4:0] OP_SRL   = 5'd5;
    localparam logic [4:0] OP_SRA   = 5'd6;
    localparam logic [4:0] OP_ADD   = 5'd7;
    localparam logic [4:0] OP_SUB   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic signed [DATA_W-1:0] a_s, b_s;
    logic [SH_W-1:0]          shamt;
    logic [DATA_W-1:0]        alu_res;
    logic                     alu_ok, is_md;

    assign a_s   = reg1_i;
    assign b_s   = reg2_i;
    assign shamt = reg1_i[SH_W-1:0];
    assign is_md = (op_i >= OP_MULT) && (op_i <= OP_DIVU);

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (op_i)
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_NOR:  alu_res = ~(reg1_i | reg2_i);
            OP_SLL:  alu_res = reg2_i << shamt;
            OP_SRL:  alu_res = reg2_i >> shamt;
            OP_SRA:  alu_res = b_s >>> shamt;
            OP_ADD:  alu_res = reg1_i + reg2_i;
            OP_SUB:  alu_res = reg1_i - reg2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default: alu_ok  = 1'b0;
        endcase
    end

    state_t              state, state_n;
    logic [SH_W-1:0]     cnt;
    logic [DATA_W-1:0]   md_opa, md_hi, md_lo, md_dividend;
    logic                md_div, md_neg_q, md_neg_r, md_div0;
    logic                start, stall;
    logic                md_signed, sa, sb;

    assign md_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign sa        = md_signed & reg1_i[DATA_W-1];
    assign sb        = md_signed & reg2_i[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // DONE never restarts: upstream still shows the same mul/div there.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i && is_md) begin
                    stall = 1'b1;
                    if (!flush_i) begin
                        start   = 1'b1;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == CNT_LAST) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
        if (rst)     stall   = 1'b0;
    end

    assign stall_req_o = stall;

    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (start)         cnt <= '0;
        else if (state == BUSY) cnt <= cnt + SH_W'(1);
    end

    // One radix-2 step: shift-add multiply (product shifts right through
    // {hi,lo}) or restoring divide (dividend shifts left out of lo into hi).
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic [DATA_W-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_opa} : '0);
        div_shift = {md_hi, md_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, md_opa};
        if (md_div) begin
            step_hi = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
            step_lo = {md_lo[DATA_W-2:0], ~div_diff[DATA_W]};
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], md_lo[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            md_div      <= (op_i == OP_DIV) || (op_i == OP_DIVU);
            md_neg_q    <= sa ^ sb;
            md_neg_r    <= sa;
            md_div0     <= (reg2_i == '0);
            md_dividend <= reg1_i;
            md_hi       <= '0;
            if ((op_i == OP_DIV) || (op_i == OP_DIVU)) begin
                md_opa <= cond_neg(reg2_i, sb);
                md_lo  <= cond_neg(reg1_i, sa);
            end else begin
                md_opa <= cond_neg(reg1_i, sa);
                md_lo  <= cond_neg(reg2_i, sb);
            end
        end else if (state == BUSY) begin
            md_hi <= step_hi;
            md_lo <= step_lo;
        end
    end

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi, res_lo;

    always_comb begin
        prod = cond_neg2({md_hi, md_lo}, md_neg_q);
        if (!md_div) begin
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end else if (md_div0) begin
            res_hi = md_dividend;
            res_lo = '1;
        end else begin
            res_hi = cond_neg(md_hi, md_neg_r);
            res_lo = cond_neg(md_lo, md_neg_q);
        end
    end

    // EX/MEM output register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o   <= 1'b0;
            wdata_o   <= '0;
            waddr_o   <= '0;
            write_o   <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
            hilo_we_o <= 1'b0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            write_o   <= 1'b0;
            hilo_we_o <= 1'b0;
        end else begin
            case (state)
                DONE: begin
                    valid_o   <= 1'b1;
                    write_o   <= 1'b0;
                    wdata_o   <= '0;
                    waddr_o   <= waddr_i;
                    hi_o      <= res_hi;
                    lo_o      <= res_lo;
                    hilo_we_o <= 1'b1;
                end
                BUSY: begin
                    valid_o   <= 1'b0;
                    write_o   <= 1'b0;
                    hilo_we_o <= 1'b0;
                end
                default: begin
                    hilo_we_o <= 1'b0;
                    waddr_o   <= waddr_i;
                    if (valid_i && is_md) begin
                        valid_o <= 1'b0;
                        write_o <= 1'b0;
                        wdata_o <= '0;
                    end else begin
                        valid_o <= valid_i;
                        write_o <= valid_i & reg_write_i & alu_ok;
                        wdata_o <= alu_ok ? alu_res : '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage: directed and randomized ALU and
// mul/div traffic compared against an arithmetic reference model.
module tb_ex_muldiv_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic [4:0]        op_i;
    logic [DATA_W-1:0] reg1_i, reg2_i;
    logic [ADDR_W-1:0] waddr_i;
    logic              reg_write_i;
    logic              flush_i;
    logic              valid_o;
    logic [DATA_W-1:0] wdata_o;
    logic [ADDR_W-1:0] waddr_o;
    logic              write_o;
    logic [DATA_W-1:0] hi_o, lo_o;
    logic              hilo_we_o;
    logic              stall_req_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_hi, last_lo;

    always #5 clk = ~clk;

    ex_muldiv_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i),
        .reg_write_i(reg_write_i), .flush_i(flush_i),
        .valid_o(valid_o), .wdata_o(wdata_o), .waddr_o(waddr_o),
        .write_o(write_o), .hi_o(hi_o), .lo_o(lo_o),
        .hilo_we_o(hilo_we_o), .stall_req_o(stall_req_o)
    );

    function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ok);
        ok  = 1'b1;
        res = 32'h0;
        case (op)
            5'd0:  res = a | b;
            5'd1:  res = a & b;
            5'd2:  res = a ^ b;
            5'd3:  res = ~(a | b);
            5'd4:  res = b << a[4:0];
            5'd5:  res = b >> a[4:0];
            5'd6:  res = $signed(b) >>> a[4:0];
            5'd7:  res = a + b;
            5'd8:  res = a - b;
            5'd9:  res = {31'b0, ($signed(a) < $signed(b))};
            5'd10: res = {31'b0, (a < b)};
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic void ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      x, y, q, r;
        logic [63:0] p;
        x = $signed(a);
        y = $signed(b);
        p = 64'h0;
        case (op)
            5'd11: p = x * y;
            5'd12: p = {32'b0, a} * {32'b0, b};
            5'd13: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = x / y;
                    r = x % y;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else            p = {a % b, a / b};
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    task automatic idle_inputs();
        valid_i = 0; op_i = 0; reg1_i = 0; reg2_i = 0;
        waddr_i = 0; reg_write_i = 0; flush_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_req_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL reset_write got=%b want=0", write_o); end
        checks++; if (hilo_we_o !== 1'b0) begin failures++; $display("FAIL reset_hilo_we got=%b want=0", hilo_we_o); end
        checks++; if (wdata_o !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h want=0", wdata_o); end
        checks++; if (waddr_o !== 5'h0) begin failures++; $display("FAIL reset_waddr got=%h want=0", waddr_o); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h/%h want=0/0", hi_o, lo_o); end
        rst = 0;
        last_hi = 0;
        last_lo = 0;
    endtask

    task automatic test_or();
        valid_i = 1; op_i = 5'd0; reg1_i = 32'h0000F0F0; reg2_i = 32'h0F0F0000;
        reg_write_i = 1; waddr_i = 5'd3;
        #1;
        checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL or_stall got=%b want=0", stall_req_o); end
        @(posedge clk); #1;
        valid_i = 0;
        checks++; if (wdata_o !== 32'h0F0FF0F0) begin failures++; $display("FAIL or_wdata got=%h want=0f0ff0f0", wdata_o); end
        checks++; if (write_o !== 1'b1) begin failures++; $display("FAIL or_write got=%b want=1", write_o); end
        checks++; if (waddr_o !== 5'd3) begin failures++; $display("FAIL or_waddr got=%0d want=3", waddr_o); end
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL or_valid got=%b want=1", valid_o); end
        checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL or_stall_after got=%b want=0", stall_req_o); end
    endtask

    task automatic test_shift_compare();
        logic [4:0]  t_op[4];
        logic [31:0] t_a[4], t_b[4], t_exp[4];
        t_op  = '{5'd6, 5'd9, 5'd10, 5'd8};
        t_a   = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        t_b   = '{32'h80000000, 32'd1, 32'd1, 32'd1};
        t_exp = '{32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            valid_i = 1; reg_write_i = 1; waddr_i = 5'(i + 1);
            op_i = t_op[i]; reg1_i = t_a[i]; reg2_i = t_b[i];
            @(posedge clk); #1;
            checks++;
            if (wdata_o !== t_exp[i] || valid_o !== 1'b1 || write_o !== 1'b1)
                begin failures++; $display("FAIL dir_alu%0d got=%h/v%b/w%b want=%h/v1/w1", i, wdata_o, valid_o, write_o, t_exp[i]); end
        end
        valid_i = 0;
    endtask

    task automatic test_random_alu();
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic        ok, vi, rw;
        logic [4:0]  wa;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op >= 5'd11 && op <= 5'd14) op = op + 5'd4;
            a = $urandom; b = $urandom;
            if (i % 4 == 0) a = 32'($urandom_range(0, 40));
            vi = ($urandom_range(0, 4) != 0);
            rw = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            ref_alu(op, a, b, res, ok);
            valid_i = vi; op_i = op; reg1_i = a; reg2_i = b; reg_write_i = rw; waddr_i = wa;
            #1;
            checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL rnd_stall%0d got=%b want=0", i, stall_req_o); end
            @(posedge clk); #1;
            checks++;
            if (valid_o !== vi || write_o !== (vi & rw & ok))
                begin failures++; $display("FAIL rnd_ctl%0d op=%0d got=v%b/w%b want=v%b/w%b", i, op, valid_o, write_o, vi, vi & rw & ok); end
            if (vi) begin
                checks++;
                if (wdata_o !== (ok ? res : 32'h0) || waddr_o !== wa)
                    begin failures++; $display("FAIL rnd_data%0d op=%0d a=%h b=%h got=%h@%0d want=%h@%0d", i, op, a, b, wdata_o, waddr_o, ok ? res : 32'h0, wa); end
            end
        end
        valid_i = 0;
    endtask

    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, input bit follow_add);
        logic [31:0] eh, el;
        int n;
        ref_md(op, a, b, eh, el);
        valid_i = 1; op_i = op; reg1_i = a; reg2_i = b; reg_write_i = 1; waddr_i = 5'd9; flush_i = 0;
        n = 0;
        #1;
        while (stall_req_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++; if (n != DATA_W + 1) begin failures++; $display("FAIL %s_stall_cycles got=%0d want=%0d", name, n, DATA_W + 1); end
        @(posedge clk); #1;
        if (follow_add) begin
            op_i = 5'd7; reg1_i = 32'd1; reg2_i = 32'd2; waddr_i = 5'd4;
        end else begin
            valid_i = 0;
        end
        checks++; if (hilo_we_o !== 1'b1) begin failures++; $display("FAIL %s_hilo_we got=%b want=1", name, hilo_we_o); end
        checks++; if (hi_o !== eh || lo_o !== el) begin failures++; $display("FAIL %s_hilo got=%h/%h want=%h/%h", name, hi_o, lo_o, eh, el); end
        checks++; if (valid_o !== 1'b1 || write_o !== 1'b0 || wdata_o !== 32'h0)
            begin failures++; $display("FAIL %s_retire got=v%b/w%b/%h want=v1/w0/0", name, valid_o, write_o, wdata_o); end
        @(posedge clk); #1;
        valid_i = 0;
        checks++; if (hilo_we_o !== 1'b0) begin failures++; $display("FAIL %s_hilo_pulse got=%b want=0", name, hilo_we_o); end
        checks++; if (hi_o !== eh || lo_o !== el) begin failures++; $display("FAIL %s_hilo_hold got=%h/%h want=%h/%h", name, hi_o, lo_o, eh, el); end
        if (follow_add) begin
            checks++; if (valid_o !== 1'b1 || write_o !== 1'b1 || wdata_o !== 32'd3 || waddr_o !== 5'd4)
                begin failures++; $display("FAIL %s_add got=v%b/w%b/%h@%0d want=v1/w1/3@4", name, valid_o, write_o, wdata_o, waddr_o); end
            @(posedge clk); #1;
            checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL %s_add_once got=%b want=0", name, valid_o); end
        end else begin
            checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL %s_valid_after got=%b want=0", name, valid_o); end
        end
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic test_muldiv_directed();
        run_md(5'd11, 32'hFFFFFFFD, 32'd7, "mult_neg", 1'b0);
        run_md(5'd13, 32'hFFFFFFF9, 32'd2, "div_neg", 1'b0);
        run_md(5'd14, 32'h12345678, 32'd0, "divu_zero", 1'b0);
        run_md(5'd13, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0);
        run_md(5'd13, 32'h80000001, 32'd0, "div_zero", 1'b0);
    endtask

    task automatic test_muldiv_random();
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 5'($urandom_range(11, 14));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i == 0) b = 32'hFFFFFFFF;
            run_md(op, a, b, "md_rnd", 1'b0);
        end
    endtask

    task automatic test_abort(input bit use_rst);
        int pulses;
        valid_i = 1; op_i = 5'd12; reg1_i = $urandom; reg2_i = $urandom; reg_write_i = 1; waddr_i = 5'd7;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (stall_req_o !== 1'b1) begin failures++; $display("FAIL abort_busy_stall got=%b want=1", stall_req_o); end
        valid_i = 0;
        if (use_rst) begin
            rst = 1;
            #1;
            checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL rst_stall_low got=%b want=0", stall_req_o); end
        end else begin
            flush_i = 1;
        end
        @(posedge clk); #1;
        rst = 0; flush_i = 0;
        checks++; if (stall_req_o !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b want=0", stall_req_o); end
        checks++; if (valid_o !== 1'b0 || write_o !== 1'b0 || hilo_we_o !== 1'b0)
            begin failures++; $display("FAIL abort_ctl got=v%b/w%b/h%b want=0/0/0", valid_o, write_o, hilo_we_o); end
        if (use_rst) begin
            last_hi = 0;
            last_lo = 0;
            checks++; if (wdata_o !== 32'h0 || waddr_o !== 5'h0)
                begin failures++; $display("FAIL rst_data got=%h@%0d want=0@0", wdata_o, waddr_o); end
        end
        checks++; if (hi_o !== last_hi || lo_o !== last_lo)
            begin failures++; $display("FAIL abort_hilo got=%h/%h want=%h/%h", hi_o, lo_o, last_hi, last_lo); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (hilo_we_o === 1'b1 || stall_req_o === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL abort_late_activity got=%0d want=0", pulses); end
    endtask

    task automatic test_back_to_back();
        run_md(5'd12, 32'd5, 32'd6, "b2b", 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_or();
        test_shift_compare();
        test_random_alu();
        test_muldiv_directed();
        test_muldiv_random();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
